jtframe_hps_player: RTL and testbench



---
 rtl/jtframe_hps_pkg.sv | 21 ++
 rtl/jtframe_hps_player_if.sv | 21 ++
 rtl/jtframe_hps_player.sv | 132 +++++++++++++
 tb/tb_jtframe_hps_player.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_hps_pkg.sv
// Shared types and width helpers for the HPS download player.
package jtframe_hps_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCapture,
        StStrobe,
        StGap,
        StFinish
    } state_e;

    function automatic int unsigned hps_dw(input int unsigned wide);
        return (wide != 0) ? 16 : 8;
    endfunction

    function automatic int unsigned hps_step(input int unsigned wide);
        return (wide != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtframe_hps_player_if.sv
// ioctl download bus between the player (master) and the consuming core (slave).
interface jtframe_hps_player_if #(
    parameter int unsigned DW = 8
) ();
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [DW-1:0] ioctl_dout;
    logic          ioctl_wait;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait
    );
endinterface

// File: rtl/jtframe_hps_player.sv
// Replays a ROM image onto the ioctl download bus, one write per LOAD/CAPTURE/STROBE pass,
// with an optional idle gap after each strobe and a software-visible status register.
module jtframe_hps_player
    import jtframe_hps_pkg::*;
#(
    parameter int unsigned WIDE        = 0,
    parameter int unsigned WR_GAP      = 2,
    parameter logic [31:0] STATUS_INIT = 32'd0,
    localparam int unsigned DW         = hps_dw(WIDE)
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [24:0]          len,
    input  logic [7:0]           index,
    output logic [24:0]          src_addr,
    input  logic [DW-1:0]        src_data,
    jtframe_hps_player_if.master ioctl,
    output logic                 done,
    input  logic [31:0]          status_in,
    input  logic                 status_set,
    output logic [31:0]          status
);

    localparam int unsigned STEP = hps_step(WIDE);
    localparam int unsigned GW   = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    state_e        state_q, state_d;
    // One extra bit so addr+STEP past a 2^25-1 length cannot wrap.
    logic [25:0]   addr_q, addr_d;
    logic [24:0]   len_q, len_d;
    logic [7:0]    index_q, index_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [24:0]   waddr_q, waddr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   status_q, status_d;
    logic          wr;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        index_d  = index_q;
        dout_d   = dout_q;
        waddr_d  = waddr_q;
        gap_d    = gap_q;
        status_d = status_set ? status_in : status_q;
        wr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != 25'd0) begin
                        len_d   = len;
                        index_d = index;
                        addr_d  = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StLoad:    state_d = StCapture;
            StCapture: begin
                dout_d  = src_data;
                waddr_d = addr_q[24:0];
                state_d = StStrobe;
            end
            StStrobe: begin
                if (!ioctl.ioctl_wait) begin
                    wr     = 1'b1;
                    addr_d = addr_q + 26'(STEP);
                    gap_d  = '0;
                    if (WR_GAP != 0) begin
                        state_d = StGap;
                    end else begin
                        state_d = (addr_d >= {1'b0, len_q}) ? StFinish : StLoad;
                    end
                end
            end
            StGap: begin
                if (gap_q == GW'(WR_GAP - 1)) begin
                    state_d = (addr_q >= {1'b0, len_q}) ? StFinish : StLoad;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Abort wins over a strobe in the same cycle.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            wr      = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            index_q  <= '0;
            dout_q   <= '0;
            waddr_q  <= '0;
            gap_q    <= '0;
            status_q <= STATUS_INIT;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            index_q  <= index_d;
            dout_q   <= dout_d;
            waddr_q  <= waddr_d;
            gap_q    <= gap_d;
            status_q <= status_d;
        end
    end

    assign src_addr             = addr_q[24:0];
    assign ioctl.ioctl_download = (state_q == StLoad) || (state_q == StCapture) ||
                                  (state_q == StStrobe) || (state_q == StGap);
    assign ioctl.ioctl_index    = index_q;
    assign ioctl.ioctl_wr       = wr;
    assign ioctl.ioctl_addr     = waddr_q;
    assign ioctl.ioctl_dout     = dout_q;
    assign done                 = (state_q == StFinish) && !abort;
    assign status               = status_q;

endmodule

// File: tb/tb_jtframe_hps_player.sv
// Directed bench: an 8-bit and a 16-bit player side by side, each fed by a one-cycle ROM.
module tb_jtframe_hps_player;

    localparam logic [31:0] INIT0 = 32'hCAFE_0001;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start0, start1, abort0, abort1;
    logic [24:0] len;
    logic [7:0]  index;
    logic [31:0] status_in;
    logic        status_set;
    logic [24:0] src_addr0, src_addr1;
    logic [7:0]  rom0_q;
    logic [15:0] rom1_q;
    logic        done0, done1;
    logic [31:0] status0, status1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    jtframe_hps_player_if #(.DW(8))  io0 ();
    jtframe_hps_player_if #(.DW(16)) io1 ();

    jtframe_hps_player #(.WIDE(0), .WR_GAP(2), .STATUS_INIT(INIT0)) u0 (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start0), .abort(abort0), .len(len),
        .index(index), .src_addr(src_addr0), .src_data(rom0_q), .ioctl(io0),
        .done(done0), .status_in(status_in), .status_set(status_set), .status(status0)
    );

    jtframe_hps_player #(.WIDE(1), .WR_GAP(2), .STATUS_INIT(32'd0)) u1 (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start1), .abort(abort1), .len(len),
        .index(index), .src_addr(src_addr1), .src_data(rom1_q), .ioctl(io1),
        .done(done1), .status_in(status_in), .status_set(status_set), .status(status1)
    );

    always_ff @(posedge clk_sys) begin
        rom0_q <= 8'hA0 + src_addr0[7:0];
        rom1_q <= 16'hC000 | {8'h00, src_addr1[7:0]};
    end

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({io0.ioctl_download, io0.ioctl_wr, done0, io1.ioctl_download, io1.ioctl_wr, done1}
            !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b%b%b%b%b%b exp 000000", io0.ioctl_download,
                     io0.ioctl_wr, done0, io1.ioctl_download, io1.ioctl_wr, done1);
        end
        n_cmp++;
        if (io0.ioctl_addr !== 25'd0 || io0.ioctl_dout !== 8'd0 || src_addr0 !== 25'd0 ||
            io0.ioctl_index !== 8'd0 || io1.ioctl_dout !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data got addr=%h dout=%h src=%h idx=%h dout1=%h exp all 0",
                     io0.ioctl_addr, io0.ioctl_dout, src_addr0, io0.ioctl_index, io1.ioctl_dout);
        end
        n_cmp++;
        if (status0 !== INIT0 || status1 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_status got %h/%h exp %h/00000000", status0, status1, INIT0);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_status();
        status_in  = 32'h0000_0105;
        status_set = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (status0 !== INIT0) begin
            n_err++;
            $display("FAIL status_early got %h exp %h", status0, INIT0);
        end
        next_cycle();
        status_set = 1'b0;
        status_in  = 32'hFFFF_FFFF;
        @(negedge clk_sys);
        n_cmp++;
        if (status0 !== 32'h105 || status1 !== 32'h105) begin
            n_err++;
            $display("FAIL status_set got %h/%h exp 00000105", status0, status1);
        end
        next_cycle();
    endtask

    // Four writes, 5 cycles apart, starting 3 cycles after the start cycle.
    task automatic test_basic();
        logic exp_wr;
        int   k;
        len   = 25'd4;
        index = 8'h12;
        for (int c = 0; c <= 24; c++) begin
            start0 = (c == 0);
            @(negedge clk_sys);
            exp_wr = (c >= 3) && (c <= 18) && ((c - 3) % 5 == 0);
            n_cmp++;
            if (io0.ioctl_wr !== exp_wr) begin
                n_err++;
                $display("FAIL basic_wr c=%0d got %b exp %b", c, io0.ioctl_wr, exp_wr);
            end
            if (exp_wr) begin
                k = (c - 3) / 5;
                n_cmp++;
                if (io0.ioctl_addr !== 25'(k) || io0.ioctl_dout !== 8'(8'hA0 + k)) begin
                    n_err++;
                    $display("FAIL basic_data c=%0d got %h/%h exp %h/%h", c, io0.ioctl_addr,
                             io0.ioctl_dout, k, 8'(8'hA0 + k));
                end
            end
            n_cmp++;
            if (done0 !== (c == 21)) begin
                n_err++;
                $display("FAIL basic_done c=%0d got %b", c, done0);
            end
            n_cmp++;
            if (io0.ioctl_download !== (c >= 1 && c <= 20)) begin
                n_err++;
                $display("FAIL basic_dl c=%0d got %b", c, io0.ioctl_download);
            end
            next_cycle();
        end
        n_cmp++;
        if (io0.ioctl_index !== 8'h12) begin
            n_err++;
            $display("FAIL basic_index got %h exp 12", io0.ioctl_index);
        end
    endtask

    // 16-bit bus, odd length: three words at byte addresses 0, 2, 4.
    task automatic test_wide();
        logic exp_wr;
        int   k;
        len   = 25'd5;
        index = 8'h21;
        for (int c = 0; c <= 20; c++) begin
            start1 = (c == 0);
            @(negedge clk_sys);
            exp_wr = (c == 3) || (c == 8) || (c == 13);
            n_cmp++;
            if (io1.ioctl_wr !== exp_wr) begin
                n_err++;
                $display("FAIL wide_wr c=%0d got %b exp %b", c, io1.ioctl_wr, exp_wr);
            end
            if (exp_wr) begin
                k = 2 * ((c - 3) / 5);
                n_cmp++;
                if (io1.ioctl_addr !== 25'(k) || io1.ioctl_dout !== 16'(16'hC000 + k)) begin
                    n_err++;
                    $display("FAIL wide_data c=%0d got %h/%h exp %h/%h", c, io1.ioctl_addr,
                             io1.ioctl_dout, k, 16'(16'hC000 + k));
                end
            end
            n_cmp++;
            if (done1 !== (c == 16) || io1.ioctl_download !== (c >= 1 && c <= 15)) begin
                n_err++;
                $display("FAIL wide_ctrl c=%0d got done=%b dl=%b", c, done1,
                         io1.ioctl_download);
            end
            next_cycle();
        end
    endtask

    // Wait held for 7 cycles over the second strobe pushes it from cycle 8 to 15.
    task automatic test_wait();
        logic exp_wr;
        len   = 25'd4;
        index = 8'h34;
        for (int c = 0; c <= 30; c++) begin
            start0          = (c == 0);
            io0.ioctl_wait  = (c >= 8) && (c <= 14);
            @(negedge clk_sys);
            exp_wr = (c == 3) || (c == 15) || (c == 20) || (c == 25);
            n_cmp++;
            if (io0.ioctl_wr !== exp_wr) begin
                n_err++;
                $display("FAIL wait_wr c=%0d got %b exp %b", c, io0.ioctl_wr, exp_wr);
            end
            if (c >= 8 && c <= 15) begin
                n_cmp++;
                if (io0.ioctl_addr !== 25'd1 || io0.ioctl_dout !== 8'hA1) begin
                    n_err++;
                    $display("FAIL wait_hold c=%0d got %h/%h exp 1/a1", c, io0.ioctl_addr,
                             io0.ioctl_dout);
                end
            end
            n_cmp++;
            if (done0 !== (c == 28)) begin
                n_err++;
                $display("FAIL wait_done c=%0d got %b", c, done0);
            end
            next_cycle();
        end
        io0.ioctl_wait = 1'b0;
    endtask

    task automatic test_abort();
        logic exp_wr;
        len   = 25'd4;
        index = 8'h45;
        for (int c = 0; c <= 24; c++) begin
            start0 = (c == 0);
            abort0 = (c == 13);
            @(negedge clk_sys);
            exp_wr = (c == 3) || (c == 8);
            n_cmp++;
            if (io0.ioctl_wr !== exp_wr) begin
                n_err++;
                $display("FAIL abort_wr c=%0d got %b exp %b", c, io0.ioctl_wr, exp_wr);
            end
            n_cmp++;
            if (done0 !== 1'b0 || io0.ioctl_download !== (c >= 1 && c <= 13)) begin
                n_err++;
                $display("FAIL abort_ctrl c=%0d got done=%b dl=%b", c, done0,
                         io0.ioctl_download);
            end
            next_cycle();
        end
        abort0 = 1'b0;
    endtask

    task automatic test_zero_busy();
        logic exp_wr;
        len   = 25'd0;
        index = 8'h50;
        for (int c = 0; c <= 3; c++) begin
            start0 = (c == 0);
            @(negedge clk_sys);
            n_cmp++;
            if (done0 !== (c == 1) || io0.ioctl_download !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len c=%0d got done=%b dl=%b exp done=%b dl=0", c, done0,
                         io0.ioctl_download, (c == 1));
            end
            next_cycle();
        end
        index = 8'h56;
        for (int c = 0; c <= 23; c++) begin
            start0 = (c == 0) || (c == 5);
            len    = (c == 5) ? 25'd2 : 25'd4;
            index  = (c == 5) ? 8'h99 : 8'h56;
            @(negedge clk_sys);
            exp_wr = (c >= 3) && (c <= 18) && ((c - 3) % 5 == 0);
            n_cmp++;
            if (io0.ioctl_wr !== exp_wr || done0 !== (c == 21)) begin
                n_err++;
                $display("FAIL busy_start c=%0d got wr=%b done=%b exp wr=%b done=%b", c,
                         io0.ioctl_wr, done0, exp_wr, (c == 21));
            end
            next_cycle();
        end
        n_cmp++;
        if (io0.ioctl_index !== 8'h56) begin
            n_err++;
            $display("FAIL busy_index got %h exp 56", io0.ioctl_index);
        end
    endtask

    task automatic test_reset_mid();
        len   = 25'd4;
        index = 8'h77;
        for (int c = 0; c <= 8; c++) begin
            start0 = (c == 0);
            next_cycle();
        end
        // Now in the gap after the second write: addr=1, dout=A1, index=77.
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({io0.ioctl_download, io0.ioctl_wr, done0} !== 3'b000 ||
            io0.ioctl_addr !== 25'd0 || io0.ioctl_dout !== 8'd0 || src_addr0 !== 25'd0 ||
            io0.ioctl_index !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_out got dl=%b wr=%b done=%b addr=%h dout=%h src=%h idx=%h",
                     io0.ioctl_download, io0.ioctl_wr, done0, io0.ioctl_addr, io0.ioctl_dout,
                     src_addr0, io0.ioctl_index);
        end
        n_cmp++;
        if (status0 !== INIT0 || status1 !== 32'd0) begin
            n_err++;
            $display("FAIL midreset_status got %h/%h exp %h/00000000", status0, status1, INIT0);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_sys);
            n_cmp++;
            if (io0.ioctl_wr !== 1'b0 || io0.ioctl_download !== 1'b0 || done0 !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_idle c=%0d got wr=%b dl=%b done=%b", c, io0.ioctl_wr,
                         io0.ioctl_download, done0);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start0         = 1'b0;
        start1         = 1'b0;
        abort0         = 1'b0;
        abort1         = 1'b0;
        len            = '0;
        index          = '0;
        status_in      = '0;
        status_set     = 1'b0;
        io0.ioctl_wait = 1'b0;
        io1.ioctl_wait = 1'b0;

        test_reset();
        test_status();
        test_basic();
        test_wide();
        test_wait();
        test_abort();
        test_zero_busy();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
